// File: rtl/shifter_extender_pkg.sv
// Shared types and constants for the operand-2 shifter/extender.
package shifter_pkg;

  // Clamp on register-specified LSL/LSR iteration count
  localparam int MAX_LSX = 33;

  // One-bit step performed on each SHIFT cycle
  typedef enum logic [2:0] {
    OP_LSL = 3'd0,
    OP_LSR = 3'd1,
    OP_ASR = 3'd2,
    OP_ROR = 3'd3,
    OP_RRX = 3'd4
  } shift_op_e;

  // Instruction classes selected by ir[27:25]
  localparam logic [2:0] CLS_DP_SH   = 3'b000;
  localparam logic [2:0] CLS_ROT_IMM = 3'b001;
  localparam logic [2:0] CLS_LS_IMM  = 3'b010;
  localparam logic [2:0] CLS_LS_REG  = 3'b011;
  localparam logic [2:0] CLS_BRANCH  = 3'b101;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shifter_extender_if.sv
// Handshake and operand bus between the control unit and the shifter.
interface shifter_extender_if #(parameter int DATA_W = 32);
  logic              start;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] rm;
  logic [7:0]        rs;
  logic              carry_in;
  logic              ready;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              carry_out;

  // Control unit side
  modport master (
    output start, ir, rm, rs, carry_in,
    input  ready, done, result, carry_out
  );

  // Shifter side
  modport slave (
    input  start, ir, rm, rs, carry_in,
    output ready, done, result, carry_out
  );
endinterface

// File: rtl/shifter_extender_shift_decode.sv
// Combinational decode of the instruction into initial operand, step type,
// iteration count and the value used when no iteration is needed.
module shift_decode
  import shifter_pkg::*;
(
  input  logic [31:0] ir,
  input  logic [31:0] rm,
  input  logic [7:0]  rs,
  input  logic        carry_in,
  output logic [31:0] operand,
  output shift_op_e   op,
  output logic [5:0]  n,
  output logic [31:0] spec_result,
  output logic        spec_carry
);

  logic [4:0] imm_amt;
  logic [1:0] sh_type;
  logic       unused_ir;

  assign imm_amt   = ir[11:7];
  assign sh_type   = ir[6:5];
  // Condition field and branch link bit play no part in operand 2
  assign unused_ir = ^{ir[31:28], ir[24]};

  // Class decode; defaults describe "no shift, pass rm, keep C"
  always_comb begin
    operand     = rm;
    op          = OP_LSL;
    n           = 6'd0;
    spec_result = rm;
    spec_carry  = carry_in;
    case (ir[27:25])
      CLS_ROT_IMM: begin
        operand     = {24'b0, ir[7:0]};
        op          = OP_ROR;
        n           = {1'b0, ir[11:8], 1'b0};
        spec_result = {24'b0, ir[7:0]};
      end
      CLS_DP_SH, CLS_LS_REG: begin
        if (ir[27:25] == CLS_DP_SH && ir[4]) begin
          // Register-specified amount
          if (rs != 8'd0) begin
            case (sh_type)
              2'b00, 2'b01: begin
                op = (sh_type == 2'b00) ? OP_LSL : OP_LSR;
                n  = (rs > 8'(MAX_LSX)) ? 6'(MAX_LSX) : rs[5:0];
              end
              2'b10: begin
                op = OP_ASR;
                n  = (rs > 8'd32) ? 6'd32 : rs[5:0];
              end
              default: begin
                op = OP_ROR;
                if (rs[4:0] == 5'd0) begin
                  // Rotation by a multiple of 32: value unchanged, C = bit 31
                  n          = 6'd0;
                  spec_carry = rm[31];
                end else begin
                  n = {1'b0, rs[4:0]};
                end
              end
            endcase
          end
        end else begin
          // Immediate amount; zero encodes LSR/ASR #32 and RRX
          case (sh_type)
            2'b00: begin
              op = OP_LSL;
              n  = {1'b0, imm_amt};
            end
            2'b01: begin
              op = OP_LSR;
              n  = (imm_amt == 5'd0) ? 6'd32 : {1'b0, imm_amt};
            end
            2'b10: begin
              op = OP_ASR;
              n  = (imm_amt == 5'd0) ? 6'd32 : {1'b0, imm_amt};
            end
            default: begin
              if (imm_amt == 5'd0) begin
                op = OP_RRX;
                n  = 6'd1;
              end else begin
                op = OP_ROR;
                n  = {1'b0, imm_amt};
              end
            end
          endcase
        end
      end
      CLS_LS_IMM: spec_result = {20'b0, ir[11:0]};
      CLS_BRANCH: spec_result = {{6{ir[23]}}, ir[23:0], 2'b00};
      default:    spec_result = 32'd0;
    endcase
  end

endmodule

// File: rtl/shifter_extender.sv
// Operand-2 generator: iterates one shift bit per clock under start/done.
module shifter_extender
  import shifter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               clr,
  shifter_extender_if.slave  bus
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              carry_q, carry_d;
  logic [5:0]        count_q, count_d;
  shift_op_e         op_q, op_d;
  logic              cin_q, cin_d;

  logic [31:0] dec_operand;
  shift_op_e   dec_op;
  logic [5:0]  dec_n;
  logic [31:0] dec_spec_result;
  logic        dec_spec_carry;

  shift_decode u_decode (
    .ir          (bus.ir),
    .rm          (bus.rm),
    .rs          (bus.rs),
    .carry_in    (bus.carry_in),
    .operand     (dec_operand),
    .op          (dec_op),
    .n           (dec_n),
    .spec_result (dec_spec_result),
    .spec_carry  (dec_spec_carry)
  );

  assign bus.ready     = (state_q == ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.carry_out = carry_q;

  // Next-state and datapath: load on accepted start, one-bit step per SHIFT edge
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    count_d  = count_q;
    op_d     = op_q;
    cin_d    = cin_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_d  = dec_op;
          cin_d = bus.carry_in;
          if (dec_n == 6'd0) begin
            result_d = dec_spec_result;
            carry_d  = dec_spec_carry;
            count_d  = 6'd0;
            state_d  = ST_DONE;
          end else begin
            result_d = dec_operand;
            count_d  = dec_n;
            state_d  = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        case (op_q)
          OP_LSL: begin
            carry_d  = result_q[31];
            result_d = {result_q[30:0], 1'b0};
          end
          OP_LSR: begin
            carry_d  = result_q[0];
            result_d = {1'b0, result_q[31:1]};
          end
          OP_ASR: begin
            carry_d  = result_q[0];
            result_d = {result_q[31], result_q[31:1]};
          end
          OP_ROR: begin
            carry_d  = result_q[0];
            result_d = {result_q[0], result_q[31:1]};
          end
          OP_RRX: begin
            carry_d  = result_q[0];
            result_d = {cin_q, result_q[31:1]};
          end
          default: ;
        endcase
        count_d = count_q - 6'd1;
        if (count_q == 6'd1) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; clr abandons any operation in progress
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      count_q  <= 6'd0;
      op_q     <= OP_LSL;
      cin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      count_q  <= count_d;
      op_q     <= op_d;
      cin_q    <= cin_d;
    end
  end

endmodule

// File: tb/tb_shifter_extender.sv
// Directed bench for shifter_extender with hand-computed expectations.
module tb_shifter_extender;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  shifter_extender_if bus_if ();

  shifter_extender #(.DATA_W(32)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one operation, then count edges after edge 0 until done is seen
  task automatic run_op(input string tag, input logic [31:0] t_ir, input logic [31:0] t_rm,
                        input logic [7:0] t_rs, input logic t_cin, input int exp_n,
                        input logic [31:0] exp_res, input logic exp_c);
    int k;
    @(negedge clk);
    bus_if.ir       = t_ir;
    bus_if.rm       = t_rm;
    bus_if.rs       = t_rs;
    bus_if.carry_in = t_cin;
    bus_if.start    = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start    = 1'b0;
    // Later input changes must not matter
    bus_if.ir       = 32'h0;
    bus_if.rm       = ~t_rm;
    bus_if.rs       = ~t_rs;
    bus_if.carry_in = ~t_cin;
    k = 0;
    while (!bus_if.done && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, " cycles"}, 32'(k), 32'(exp_n));
    check({tag, " result"}, bus_if.result, exp_res);
    check({tag, " carry"}, {31'b0, bus_if.carry_out}, {31'b0, exp_c});
    @(posedge clk);
    #1;
    check({tag, " done/ready after"}, {30'b0, bus_if.done, bus_if.ready}, 32'd1);
    $display("op %s: cycles=%0d result=%h carry=%b", tag, k, bus_if.result, bus_if.carry_out);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic [31:0] res_at_done;
    logic        c_at_done;

    bus_if.start    = 1'b0;
    bus_if.ir       = 32'h0;
    bus_if.rm       = 32'h0;
    bus_if.rs       = 8'h0;
    bus_if.carry_in = 1'b0;
    clr             = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset result", bus_if.result, 32'h0);
    check("reset carry/done/ready", {29'b0, bus_if.carry_out, bus_if.done, bus_if.ready}, 32'd1);
    @(negedge clk);
    clr = 1'b1;

    run_op("rot imm",       32'h020001FF, 32'h0,        8'd0,  1'b0, 2,  32'hC000003F, 1'b1);
    run_op("imm lsr0",      32'h00000020, 32'h80000001, 8'd0,  1'b0, 32, 32'h00000000, 1'b1);
    run_op("rrx",           32'h00000060, 32'h00000003, 8'd0,  1'b1, 1,  32'h80000001, 1'b1);
    run_op("reg asr40",     32'h00000050, 32'h80000000, 8'd40, 1'b0, 32, 32'hFFFFFFFF, 1'b1);
    run_op("reg lsl0",      32'h00000010, 32'h00001234, 8'd0,  1'b1, 0,  32'h00001234, 1'b1);
    run_op("branch",        32'h0AFFFFFE, 32'h0,        8'd0,  1'b0, 0,  32'hFFFFFFF8, 1'b0);
    run_op("ldst imm",      32'h04000ABC, 32'h0,        8'd0,  1'b1, 0,  32'h00000ABC, 1'b1);
    run_op("imm lsl4",      32'h00000200, 32'hF0000001, 8'd0,  1'b0, 4,  32'h00000010, 1'b1);
    run_op("imm asr4 c011", 32'h06000240, 32'h80000010, 8'd0,  1'b1, 4,  32'hF8000001, 1'b0);
    run_op("reg ror32",     32'h00000070, 32'h80000000, 8'd32, 1'b0, 0,  32'h80000000, 1'b1);
    run_op("reg lsr33",     32'h00000030, 32'hFFFFFFFF, 8'd33, 1'b1, 33, 32'h00000000, 1'b0);
    run_op("class 100",     32'h08000000, 32'h12345678, 8'd0,  1'b1, 0,  32'h00000000, 1'b1);

    // Second start during SHIFT is ignored; exactly one done pulse
    @(negedge clk);
    bus_if.ir       = 32'h00000020;
    bus_if.rm       = 32'h80000001;
    bus_if.carry_in = 1'b0;
    bus_if.start    = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("busy ready", {31'b0, bus_if.ready}, 32'd0);
    bus_if.ir    = 32'h00000010;
    bus_if.rm    = 32'h00005555;
    bus_if.start = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    pulses      = 0;
    res_at_done = 32'hDEADBEEF;
    c_at_done   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus_if.done) begin
        pulses++;
        res_at_done = bus_if.result;
        c_at_done   = bus_if.carry_out;
      end
      @(posedge clk);
      #1;
    end
    check("ignored start pulses", 32'(pulses), 32'd1);
    check("ignored start result", res_at_done, 32'h00000000);
    check("ignored start carry", {31'b0, c_at_done}, 32'd1);
    $display("op ignored-start: pulses=%0d result=%h carry=%b", pulses, res_at_done, c_at_done);

    // clr mid-SHIFT clears outputs immediately
    @(negedge clk);
    bus_if.ir       = 32'h00000020;
    bus_if.rm       = 32'hFFFFFFFF;
    bus_if.start    = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    clr = 1'b0;
    #1;
    check("clr result", bus_if.result, 32'h0);
    check("clr carry/done/ready", {29'b0, bus_if.carry_out, bus_if.done, bus_if.ready}, 32'd1);
    $display("op clr-mid-shift: result=%h ready=%b", bus_if.result, bus_if.ready);
    @(negedge clk);
    clr = 1'b1;
    run_op("rrx after clr", 32'h00000060, 32'h00000003, 8'd0, 1'b1, 1, 32'h80000001, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
